// File: rtl/membus_arbiter.sv
// Arbitrates one memory bus between instruction fetch (I) and hart load/store (D).
// D has priority, bounded by a streak limit while I waits; hung transfers time out with an error ack.
module membus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic              i_err,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_w,
    input  logic              d_sext,
    input  logic [1:0]        d_width,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_w,
    output logic              mem_sext,
    output logic [1:0]        mem_width,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              w_q, w_d;
    logic              sext_q, sext_d;
    logic [1:0]        width_q, width_d;
    logic              timed_out;

    // Fires in the TIMEOUT-th consecutive BUSY cycle without mem_ack; mem_ack wins.
    assign timed_out = (timer_q == TW'(TIMEOUT - 1)) && !mem_ack;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        w_d      = w_q;
        sext_d   = sext_q;
        width_d  = width_q;
        mem_req  = 1'b0;
        i_ack    = 1'b0;
        i_err    = 1'b0;
        i_rdata  = '0;
        d_ack    = 1'b0;
        d_err    = 1'b0;
        d_rdata  = '0;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || (streak_q < SW'(MAX_STREAK)))) begin
                    state_d  = BUSY_D;
                    addr_d   = d_addr;
                    wdata_d  = d_w ? d_wdata : '0;
                    w_d      = d_w;
                    sext_d   = d_sext;
                    width_d  = d_width;
                    timer_d  = '0;
                    // streak < MAX_STREAK whenever i_req is high here, so this saturates
                    streak_d = i_req ? streak_q + SW'(1) : '0;
                end else if (i_req) begin
                    state_d  = BUSY_I;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    w_d      = 1'b0;
                    sext_d   = 1'b0;
                    width_d  = WIDTH_WORD;
                    timer_d  = '0;
                    streak_d = '0;
                end
            end
            BUSY_I: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    i_ack   = 1'b1;
                    i_rdata = mem_rdata;
                    state_d = IDLE;
                end else if (timed_out) begin
                    i_ack   = 1'b1;
                    i_err   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            BUSY_D: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    d_ack   = 1'b1;
                    d_rdata = mem_rdata;
                    state_d = IDLE;
                end else if (timed_out) begin
                    d_ack   = 1'b1;
                    d_err   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            streak_q <= '0;
            timer_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            w_q      <= 1'b0;
            sext_q   <= 1'b0;
            width_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            timer_q  <= timer_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            w_q      <= w_d;
            sext_q   <= sext_d;
            width_q  <= width_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_w     = w_q;
    assign mem_sext  = sext_q;
    assign mem_width = width_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Scoreboard bench for membus_arbiter: expected transactions are queued as requests are
// issued and retired against each ack, with a small memory responder of programmable latency.
module tb_membus_arbiter;

    localparam int MAXS = 4;
    localparam int TMO  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_ack, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_w, d_sext, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_width;
    logic        mem_req, mem_w, mem_sext, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;

    membus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_w(d_w), .d_sext(d_sext),
        .d_width(d_width), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_w(mem_w),
        .mem_sext(mem_sext), .mem_width(mem_width), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          w;
        bit          sext;
        bit          err;
        logic [1:0]  width;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_delay = 0;
    bit   never_ack = 0;
    int   busy_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    function automatic exp_t mk_exp(input bit is_d, input logic [31:0] a, input logic [31:0] wd,
                                    input bit w, input bit sx, input logic [1:0] wdt,
                                    input bit err, input int cyc);
        exp_t e;
        e.is_d   = is_d;
        e.addr   = a;
        e.wdata  = w ? wd : 32'h0;
        e.w      = w;
        e.sext   = is_d ? sx : 1'b0;
        e.width  = is_d ? wdt : 2'd2;
        e.err    = err;
        e.rdata  = err ? 32'h0 : mem_model(a);
        e.cycles = cyc;
        return e;
    endfunction

    // Memory responder: updates mem_ack/mem_rdata just after each edge for the current cycle.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_req) begin
                busy_cnt  = 0;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end else begin
                mem_ack   = !never_ack && (busy_cnt == ack_delay);
                mem_rdata = mem_ack ? mem_model(mem_addr) : $urandom;
                busy_cnt++;
            end
        end
    end

    // Monitor: retire one scoreboard entry per ack.
    initial begin
        bit   prev_ack = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ack = 0;
            end else begin
                if (prev_ack) check("idle_gap", {31'h0, mem_req}, 32'h0);
                prev_ack = i_ack | d_ack;
                if (i_ack | d_ack) begin
                    check("one_ack", {31'h0, i_ack & d_ack}, 32'h0);
                    if (sb.size() == 0) begin
                        check("spurious_ack", 32'h1, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        check("port",   {31'h0, d_ack}, {31'h0, e.is_d});
                        check("mem_req", {31'h0, mem_req}, 32'h1);
                        check("addr",   mem_addr, e.addr);
                        check("wdata",  mem_wdata, e.wdata);
                        check("w",      {31'h0, mem_w}, {31'h0, e.w});
                        check("sext",   {31'h0, mem_sext}, {31'h0, e.sext});
                        check("width",  {30'h0, mem_width}, {30'h0, e.width});
                        check("latency", busy_cnt, e.cycles);
                        if (e.is_d) begin
                            check("d_err", {31'h0, d_err}, {31'h0, e.err});
                            check("d_rdata", d_rdata, e.rdata);
                            check("i_rdata_idle", i_rdata, 32'h0);
                        end else begin
                            check("i_err", {31'h0, i_err}, {31'h0, e.err});
                            check("i_rdata", i_rdata, e.rdata);
                            check("d_rdata_idle", d_rdata, 32'h0);
                        end
                        $display("txn %s addr=0x%08h w=%0d err=%0d busy_cycles=%0d",
                                 e.is_d ? "D" : "I", e.addr, e.w, e.err, busy_cnt);
                    end
                end
            end
        end
    end

    task automatic do_i(input logic [31:0] a);
        bit got = 0;
        i_addr = a;
        i_req  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (i_ack) begin got = 1; break; end
        end
        i_req = 1'b0;
        if (!got) check("i_wait_bound", 32'h0, 32'h1);
    endtask

    task automatic do_d(input logic [31:0] a, input logic [31:0] wd, input bit w,
                        input bit sx, input logic [1:0] wdt);
        bit got = 0;
        d_addr  = a;
        d_wdata = wd;
        d_w     = w;
        d_sext  = sx;
        d_width = wdt;
        d_req   = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (d_ack) begin got = 1; break; end
        end
        d_req = 1'b0;
        if (!got) check("d_wait_bound", 32'h0, 32'h1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int streak, i_rem, d_rem, i_k, d_k;
        reset = 1'b1;
        i_req = 0; i_addr = 0;
        d_req = 0; d_addr = 0; d_wdata = 0; d_w = 0; d_sext = 0; d_width = 0;
        idle_cycles(3);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_ctrl", {28'h0, mem_w, mem_sext, mem_width}, 32'h0);
        check("rst_acks", {28'h0, i_ack, d_ack, i_err, d_err}, 32'h0);
        check("rst_rdata", i_rdata | d_rdata, 32'h0);
        reset = 1'b0;
        idle_cycles(2);

        // Single fetch, ack two cycles after mem_req rises.
        ack_delay = 2;
        sb.push_back(mk_exp(0, 32'h100, 0, 0, 0, 2'd2, 0, 3));
        do_i(32'h100);
        idle_cycles(2);

        // Byte store, immediate ack.
        ack_delay = 0;
        sb.push_back(mk_exp(1, 32'h2004, 32'h55, 1, 0, 2'd0, 0, 1));
        do_d(32'h2004, 32'h55, 1, 0, 2'd0);
        idle_cycles(2);

        // Sign-extending halfword load; store data must not leak onto the bus.
        ack_delay = 1;
        sb.push_back(mk_exp(1, 32'h2202, 32'h1234, 0, 1, 2'd1, 0, 2));
        do_d(32'h2202, 32'h1234, 0, 1, 2'd1);
        idle_cycles(2);

        // Both ports held busy: predict the grant order with a streak model.
        ack_delay = 0;
        streak = 0; i_rem = 2; d_rem = 8; i_k = 0; d_k = 0;
        while (i_rem + d_rem > 0) begin
            if (d_rem > 0 && (i_rem == 0 || streak < MAXS)) begin
                sb.push_back(mk_exp(1, 32'h3000 + 4 * d_k, 32'hFFFF, 0, 0, 2'd2, 0, 1));
                streak = (i_rem > 0) ? streak + 1 : 0;
                d_rem--; d_k++;
            end else begin
                sb.push_back(mk_exp(0, 32'h4000 + 4 * i_k, 0, 0, 0, 2'd2, 0, 1));
                streak = 0;
                i_rem--; i_k++;
            end
        end
        fork
            begin
                for (int k = 0; k < 8; k++) do_d(32'h3000 + 4 * k, 32'hFFFF, 0, 0, 2'd2);
            end
            begin
                for (int k = 0; k < 2; k++) do_i(32'h4000 + 4 * k);
            end
        join
        idle_cycles(2);

        // Hung data access times out, then the waiting fetch proceeds.
        ack_delay = 1;
        sb.push_back(mk_exp(1, 32'h5000, 0, 0, 0, 2'd2, 1, TMO));
        sb.push_back(mk_exp(0, 32'h6000, 0, 0, 0, 2'd2, 0, 2));
        fork
            begin
                never_ack = 1;
                do_d(32'h5000, 0, 0, 0, 2'd2);
                never_ack = 0;
            end
            do_i(32'h6000);
        join
        idle_cycles(2);

        // mem_ack landing on the timeout cycle completes normally.
        ack_delay = TMO - 1;
        sb.push_back(mk_exp(1, 32'h7000, 0, 0, 0, 2'd2, 0, TMO));
        do_d(32'h7000, 0, 0, 0, 2'd2);
        idle_cycles(2);

        // Asynchronous reset in the middle of a data transfer.
        ack_delay = 5;
        d_addr = 32'h8000; d_w = 0; d_sext = 0; d_width = 2'd2; d_req = 1'b1;
        idle_cycles(3);
        check("busy_before_rst", {31'h0, mem_req}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst_drops_req", {31'h0, mem_req}, 32'h0);
        check("rst_drops_ack", {30'h0, i_ack, d_ack}, 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("post_rst_idle", {29'h0, mem_req, i_ack, d_ack}, 32'h0);
        end

        check("sb_empty", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
